// File: rtl/jump_sequencer_if.sv
// jump_sequencer_if: request/response bundle between the control unit and the
// jump sequencer.
//   master : drives the latched-on-start instruction fields (start, opcode,
//            funct, target, rs_index, rd_index, rs_value, pc_plus4) and
//            observes the sequencer outputs.
//   slave  : the sequencer itself; drives busy/done, the PC and register-file
//            write controls, and the fault/RAS advisory pulses.
interface jump_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                start;
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [25:0]         target;
  logic [4:0]          rs_index;
  logic [4:0]          rd_index;
  logic [PC_WIDTH-1:0] rs_value;
  logic [PC_WIDTH-1:0] pc_plus4;

  logic                busy;
  logic                done;
  logic                pc_write;
  logic [PC_WIDTH-1:0] pc_next;
  logic                reg_wr;
  logic [4:0]          reg_wr_addr;
  logic [PC_WIDTH-1:0] reg_wd;
  logic                exc_unaligned;
  logic                illegal;
  logic                ras_hit;
  logic                ras_miss;
  logic                ras_overflow;

  modport master (
    output start, opcode, funct, target, rs_index, rd_index, rs_value, pc_plus4,
    input  busy, done, pc_write, pc_next, reg_wr, reg_wr_addr, reg_wd,
           exc_unaligned, illegal, ras_hit, ras_miss, ras_overflow
  );

  modport slave (
    input  start, opcode, funct, target, rs_index, rd_index, rs_value, pc_plus4,
    output busy, done, pc_write, pc_next, reg_wr, reg_wr_addr, reg_wd,
           exc_unaligned, illegal, ras_hit, ras_miss, ras_overflow
  );
endinterface

// File: rtl/jump_sequencer.sv
// jump_sequencer: executes J / JAL / JR / JALR for the multicycle MIPS datapath.
// Sequences the link write and the PC write, faults on misaligned register
// targets or unsupported encodings, and keeps a circular return-address stack
// whose hit/miss/overflow pulses are advisory only (the jump is always taken).
// Ports:
//   clk      : clock
//   reset_in : synchronous active-high reset (wins over everything)
//   bus      : jump_sequencer_if.slave (instruction fields in, controls out)
// All outputs are decoded purely from registered state, so they are zero in
// IDLE and a reset on an edge clears every output for the following cycle.
module jump_sequencer #(
  parameter int PC_WIDTH   = 32,
  parameter int LINK_REG   = 31,
  parameter int RAS_DEPTH  = 4,
  parameter bit FUSED_LINK = 1'b0
) (
  input  logic            clk,
  input  logic            reset_in,
  jump_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LINK, JUMP, FAULT} state_t;
  typedef enum logic [2:0] {K_J, K_JAL, K_JR, K_JALR, K_ILL} kind_t;

  localparam int               PTR_W    = $clog2(RAS_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [4:0]       LINK_IDX = 5'(LINK_REG);

  state_t              state_q, state_d;
  kind_t               kind_q, kind_d;
  logic [25:0]         target_q, target_d;
  logic [4:0]          rs_index_q, rs_index_d;
  logic [4:0]          rd_index_q, rd_index_d;
  logic [PC_WIDTH-1:0] rs_value_q, rs_value_d;
  logic [PC_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [PTR_W-1:0]    ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;
  logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  kind_t               in_kind;
  logic                in_unaligned;
  logic                is_link, do_link, do_pop, ras_push, ras_match;
  logic [PC_WIDTH-1:0] ras_top, jump_abs;

  // Instruction decode of the live inputs (only used on an accepted start)
  always_comb begin
    in_kind = K_ILL;
    case (bus.opcode)
      6'h02: in_kind = K_J;
      6'h03: in_kind = K_JAL;
      6'h00: begin
        if (bus.funct == 6'h08)      in_kind = K_JR;
        else if (bus.funct == 6'h09) in_kind = K_JALR;
      end
      default: in_kind = K_ILL;
    endcase
    in_unaligned = ((in_kind == K_JR) || (in_kind == K_JALR)) &&
                   (bus.rs_value[1:0] != 2'b00);
  end

  // Next state; the operand latches only load on an accepted start, so input
  // changes during an operation are invisible to it.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    target_d   = target_q;
    rs_index_d = rs_index_q;
    rd_index_d = rd_index_q;
    rs_value_d = rs_value_q;
    pc_plus4_d = pc_plus4_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          kind_d     = in_kind;
          target_d   = bus.target;
          rs_index_d = bus.rs_index;
          rd_index_d = bus.rd_index;
          rs_value_d = bus.rs_value;
          pc_plus4_d = bus.pc_plus4;
          if ((in_kind == K_ILL) || in_unaligned)
            state_d = FAULT;
          else if (((in_kind == K_JAL) || (in_kind == K_JALR)) && !FUSED_LINK)
            state_d = LINK;
          else
            state_d = JUMP;
        end
      end
      LINK:    state_d = JUMP;
      JUMP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Link / RAS control. The link happens in LINK, or in JUMP when fused.
  always_comb begin
    is_link   = (kind_q == K_JAL) || (kind_q == K_JALR);
    do_link   = is_link && ((state_q == LINK) || ((state_q == JUMP) && FUSED_LINK));
    do_pop    = (state_q == JUMP) && (kind_q == K_JR) && (rs_index_q == LINK_IDX);
    ras_push  = do_link;
    ras_top   = ras_mem_q[ras_ptr_q - PTR_W'(1)];
    ras_match = (ras_cnt_q != '0) && (ras_top == rs_value_q);

    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (ras_push) begin
      // A full stack wraps onto its oldest entry; depth is a power of two.
      ras_ptr_d = ras_ptr_q + PTR_W'(1);
      if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + CNT_W'(1);
    end else if (do_pop && (ras_cnt_q != '0)) begin
      // Entry is consumed whether or not it matched.
      ras_ptr_d = ras_ptr_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end

    jump_abs       = pc_plus4_q;
    jump_abs[27:0] = {target_q, 2'b00};
  end

  // Output decode
  always_comb begin
    bus.busy          = (state_q != IDLE);
    bus.done          = (state_q == JUMP) || (state_q == FAULT);
    bus.pc_write      = (state_q == JUMP);
    bus.pc_next       = '0;
    bus.reg_wr        = 1'b0;
    bus.reg_wr_addr   = 5'd0;
    bus.reg_wd        = '0;
    bus.exc_unaligned = (state_q == FAULT) && (kind_q != K_ILL);
    bus.illegal       = (state_q == FAULT) && (kind_q == K_ILL);
    bus.ras_hit       = do_pop && ras_match;
    bus.ras_miss      = do_pop && !ras_match;
    bus.ras_overflow  = ras_push && (ras_cnt_q == RAS_FULL);
    if (state_q == JUMP)
      bus.pc_next = ((kind_q == K_J) || (kind_q == K_JAL)) ? jump_abs : rs_value_q;
    if (do_link) begin
      // JALR to $0 still pushes the RAS but must not write the register file.
      bus.reg_wr      = !((kind_q == K_JALR) && (rd_index_q == 5'd0));
      bus.reg_wr_addr = (kind_q == K_JAL) ? LINK_IDX : rd_index_q;
      bus.reg_wd      = pc_plus4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q   <= IDLE;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    kind_q     <= kind_d;
    target_q   <= target_d;
    rs_index_q <= rs_index_d;
    rd_index_q <= rd_index_d;
    rs_value_q <= rs_value_d;
    pc_plus4_q <= pc_plus4_d;
    if (ras_push) ras_mem_q[ras_ptr_q] <= pc_plus4_q;
  end

endmodule
